// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM state (IDLE = no owner, BUSY = transfer in flight)
//   GRANT_D/I   : grant encoding, 0 = data-side master, 1 = instruction-side master
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic GRANT_D = 1'b0;
    localparam logic GRANT_I = 1'b1;

endpackage

// File: rtl/wb_dual_master_arbiter_if.sv
// Single Wishbone port bundle, used for both master-side ports and the shared bus.
//   master modport : drives cyc/stb/we/adr/datwr/sel, receives datrd/ack/err
//   slave  modport : receives cyc/stb/we/adr/datwr/sel, drives datrd/ack/err
// Handshake: a transfer is requested while cyc & stb are high; it completes in the
// cycle the slave side raises ack (datrd valid on reads) or err. The request must be
// held stable until that cycle.
interface wb_dual_master_arbiter_if #(
    parameter int unsigned addr_width   = 32,
    parameter int unsigned data_width   = 32,
    parameter int unsigned strobe_width = data_width / 8
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [addr_width-1:0]   adr;
    logic [data_width-1:0]   datwr;
    logic [strobe_width-1:0] sel;
    logic [data_width-1:0]   datrd;
    logic                    ack;
    logic                    err;

    modport master (
        output cyc, stb, we, adr, datwr, sel,
        input  datrd, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, datwr, sel,
        output datrd, ack, err
    );
endinterface

// File: rtl/wb_arb_watchdog.sv
// Saturating cycle counter that flags a transfer the slave never acknowledges.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the counter (held while no transfer is in flight)
//   enable       : count this cycle (BUSY without ack)
//   timeout      : high in the cycle the count reaches timeout_cycles-1;
//                  the count runs past that value, so it fires once per clear.
// timeout_cycles = 0 disables the watchdog.
module wb_arb_watchdog #(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam int unsigned CNT_W = (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] LIMIT =
        (timeout_cycles == 0) ? '0 : CNT_W'(timeout_cycles - 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clear) begin
            wd_cnt_d = '0;
        end else if (enable && (wd_cnt_q != '1)) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign timeout = (timeout_cycles != 0) && enable && (wd_cnt_q == LIMIT);

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Registered arbiter between the data-side (m0) and instruction-side (m1) Wishbone
// masters and one shared Wishbone bus.
//   clock, reset : system clock, synchronous active-high reset
//   m0, m1       : master ports (arbiter acts as their slave)
//   s            : shared bus port (arbiter acts as its master; s.err is not used)
//   busy         : FSM state, high while a transfer owns the bus
//   grant        : current or most recent owner (0 = m0, 1 = m1)
// Grant is chosen in IDLE and held until ack, error (watchdog) or abort. Ties go to
// the master that did not complete the previous transfer.
module wb_dual_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned addr_width     = 32,
    parameter int unsigned data_width     = 32,
    parameter int unsigned strobe_width   = data_width / 8,
    parameter int unsigned timeout_cycles = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    wb_dual_master_arbiter_if.slave   m0,
    wb_dual_master_arbiter_if.slave   m1,
    wb_dual_master_arbiter_if.master  s,
    output logic                      busy,
    output logic                      grant
);
    arb_state_t state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       req_0, req_1;
    logic       g_cyc;
    logic       ack_g, err_g;
    logic       timeout;

    assign req_0 = m0.cyc & m0.stb;
    assign req_1 = m1.cyc & m1.stb;
    assign g_cyc = (grant_q == GRANT_I) ? m1.cyc : m0.cyc;

    wb_arb_watchdog #(
        .timeout_cycles(timeout_cycles)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == ARB_IDLE),
        .enable  ((state_q == ARB_BUSY) && !s.ack),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack_g   = 1'b0;
        err_g   = 1'b0;
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = '0;
        s.datwr = '0;
        s.sel   = '0;

        if (state_q == ARB_IDLE) begin
            if (req_0 || req_1) begin
                state_d = ARB_BUSY;
                if (req_0 && req_1) begin
                    grant_d = ~last_q;
                end else begin
                    grant_d = req_1 ? GRANT_I : GRANT_D;
                end
            end
        end else begin
            if (!g_cyc) begin
                // Owner abandoned the cycle: release the bus silently and keep
                // the round-robin history as it was.
                state_d = ARB_IDLE;
            end else begin
                s.cyc   = g_cyc;
                s.stb   = (grant_q == GRANT_I) ? m1.stb   : m0.stb;
                s.we    = (grant_q == GRANT_I) ? m1.we    : m0.we;
                s.adr   = (grant_q == GRANT_I) ? m1.adr   : m0.adr;
                s.datwr = (grant_q == GRANT_I) ? m1.datwr : m0.datwr;
                s.sel   = (grant_q == GRANT_I) ? m1.sel   : m0.sel;
                if (s.ack) begin
                    // Ack takes priority over a coincident watchdog expiry.
                    ack_g   = 1'b1;
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end else if (timeout) begin
                    err_g   = 1'b1;
                    s.cyc   = 1'b0;
                    s.stb   = 1'b0;
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= GRANT_D;
            last_q  <= GRANT_I;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign m0.ack   = ack_g & (grant_q == GRANT_D);
    assign m0.err   = err_g & (grant_q == GRANT_D);
    assign m1.ack   = ack_g & (grant_q == GRANT_I);
    assign m1.err   = err_g & (grant_q == GRANT_I);
    assign m0.datrd = s.datrd;
    assign m1.datrd = s.datrd;
    assign busy     = (state_q == ARB_BUSY);
    assign grant    = grant_q;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
module tb_wb_dual_master_arbiter;
    logic clock;
    logic reset;
    logic busy;
    logic grant;
    int   total;
    int   bad;

    wb_dual_master_arbiter_if #(.addr_width(32), .data_width(32), .strobe_width(4)) m0_if ();
    wb_dual_master_arbiter_if #(.addr_width(32), .data_width(32), .strobe_width(4)) m1_if ();
    wb_dual_master_arbiter_if #(.addr_width(32), .data_width(32), .strobe_width(4)) s_if ();

    wb_dual_master_arbiter #(
        .addr_width     (32),
        .data_width     (32),
        .strobe_width   (4),
        .timeout_cycles (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .busy  (busy),
        .grant (grant)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // checking
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] adr,
                            input logic [31:0] datwr, input logic [3:0] sel);
        m0_if.cyc = req; m0_if.stb = req; m0_if.we = we;
        m0_if.adr = adr; m0_if.datwr = datwr; m0_if.sel = sel;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] adr,
                            input logic [31:0] datwr, input logic [3:0] sel);
        m1_if.cyc = req; m1_if.stb = req; m1_if.we = we;
        m1_if.adr = adr; m1_if.datwr = datwr; m1_if.sel = sel;
    endtask

    initial begin
        logic exp_g;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        s_if.ack = 1'b0; s_if.err = 1'b0; s_if.datrd = 32'h0;
        drive_m0(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);

        // reset held with both masters requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_s_cyc", s_if.cyc, 0);
            chk("rst_busy", busy, 0);
            chk("rst_acks", {m0_if.ack, m1_if.ack, m0_if.err, m1_if.err}, 0);
        end
        reset = 1'b0;
        tick();
        chk("first_grant", grant, 0);
        chk("first_busy", busy, 1);
        s_if.ack = 1'b1;
        #1 chk("first_m0_ack", m0_if.ack, 1);
        tick();
        s_if.ack = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // single read from m0
        drive_m0(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        #1 chk("rd_idle_s_cyc", s_if.cyc, 0);
        tick();
        #1 chk("rd_s_adr", s_if.adr, 32'h100);
        chk("rd_s_cyc", s_if.cyc, 1);
        chk("rd_wait_ack", m0_if.ack, 0);
        tick();
        s_if.ack = 1'b1; s_if.datrd = 32'hDEAD_BEEF;
        #1 chk("rd_m0_ack", m0_if.ack, 1);
        chk("rd_m0_datrd", m0_if.datrd, 32'hDEAD_BEEF);
        chk("rd_m1_ack", m1_if.ack, 0);
        tick();
        s_if.ack = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // spurious ack while idle
        s_if.ack = 1'b1;
        #1 chk("spur_acks", {m0_if.ack, m1_if.ack}, 0);
        chk("spur_busy", busy, 0);
        tick();
        s_if.ack = 1'b0;

        // contention after reset: expect 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive_m0(1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 1);
            #1 chk("cont_idle", busy, 0);
            tick();
            s_if.ack = 1'b1;
            #1 chk("cont_grant", grant, exp_g);
            chk("cont_adr", s_if.adr, exp_g ? 32'hB0 : 32'hA0);
            chk("cont_acks", {m1_if.ack, m0_if.ack}, exp_g ? 2'b10 : 2'b01);
            tick();
            s_if.ack = 1'b0;
        end
        drive_m0(1'b0, 1'b0, 32'h0000_00A0, 32'h0, 4'hF);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // write passthrough on m1
        drive_m1(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011);
        tick();
        #1 chk("wr_grant", grant, 1);
        chk("wr_s_we", s_if.we, 1);
        chk("wr_s_adr", s_if.adr, 32'h40);
        chk("wr_s_datwr", s_if.datwr, 32'h1234_5678);
        chk("wr_s_sel", s_if.sel, 4'b0011);
        chk("wr_s_cyc_stb", {s_if.cyc, s_if.stb}, 2'b11);
        tick();
        s_if.ack = 1'b1;
        #1 chk("wr_acks", {m1_if.ack, m0_if.ack}, 2'b10);
        tick();
        s_if.ack = 1'b0;
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // watchdog on m0 with m1 pending
        drive_m0(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        tick();
        drive_m1(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        for (int c = 1; c <= 8; c++) begin
            #1 chk("to_m0_err", m0_if.err, (c == 8));
            chk("to_s_cyc", s_if.cyc, (c != 8));
            chk("to_m1_err", m1_if.err, 0);
            tick();
        end
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 chk("to_idle", busy, 0);
        chk("to_err_gone", m0_if.err, 0);
        tick();
        #1 chk("to_next_grant", grant, 1);
        chk("to_next_busy", busy, 1);
        s_if.ack = 1'b1;
        #1 chk("to_m1_ack", m1_if.ack, 1);
        tick();
        s_if.ack = 1'b0;
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // abort: m0 completes first so history points at m0
        drive_m0(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        tick();
        s_if.ack = 1'b1;
        #1 chk("ab_m0_ack", m0_if.ack, 1);
        tick();
        s_if.ack = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
        tick();
        #1 chk("ab_grant", grant, 1);
        drive_m1(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
        #1 chk("ab_s_cyc", s_if.cyc, 0);
        chk("ab_no_resp", {m1_if.ack, m1_if.err}, 0);
        tick();
        drive_m0(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
        #1 chk("ab_idle", busy, 0);
        tick();
        #1 chk("ab_last_kept", grant, 1);

        // reset mid-transfer
        reset = 1'b1;
        tick();
        s_if.ack = 1'b1;
        #1 chk("mrst_busy", busy, 0);
        chk("mrst_s_cyc", s_if.cyc, 0);
        chk("mrst_grant", grant, 0);
        chk("mrst_acks", {m0_if.ack, m1_if.ack}, 0);
        reset = 1'b0;
        s_if.ack = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
